pipe_hazard_unit: RTL and testbench

// Hazard/stall/flush controller for the 5-stage core (IF/ID/EX/MEM/WB).
// - Drives PC and pipeline-register enables and active-low clears.
// - Selects EX-stage operand forwarding.
// - Freezes the pipeline on multi-cycle data-memory accesses, with timeout detection.
// - Instantiated next to the core top; replaces the tied-off clear_*/EN_* nets.

---
 rtl/pipe_hazard_unit_if.sv | 65 ++++++
 rtl/pipe_hazard_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_unit_if.sv
// pipe_hazard_unit_if
// Bundle between the 5-stage core and its hazard/stall/flush controller.
// The core side (master) drives the pipeline-register fields and memory
// handshake. The hazard unit (slave) returns these signals:
//   - register enables and active-low clears,
//   - forwarding selects,
//   - the timeout flag and the FSM state,
//   - the performance counters.
// Parameters: REG_AW (register-index width), CNT_W (perf counter width).
interface pipe_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  // Hazard detection inputs (core -> hazard unit)
  logic [REG_AW-1:0] rs1_ID;
  logic [REG_AW-1:0] rs2_ID;
  logic              uses_rs1_ID;
  logic              uses_rs2_ID;
  logic [REG_AW-1:0] rs1_EX;
  logic [REG_AW-1:0] rs2_EX;
  logic [REG_AW-1:0] rd_EX;
  logic              MemRead_EX;
  logic [REG_AW-1:0] rd_MEM;
  logic              RegWrite_MEM;
  logic [REG_AW-1:0] rd_WB;
  logic              RegWrite_WB;
  logic              PCSrc_EX;
  logic              mem_access_MEM;
  logic              mem_ready;

  // Pipeline control outputs (hazard unit -> core)
  logic              EN_PC;
  logic              EN_IFID;
  logic              EN_IDEX;
  logic              EN_EXMEM;
  logic              EN_MEMWB;
  logic              clear_IFID;
  logic              clear_IDEX;
  logic              clear_EXMEM;
  logic [1:0]        forward_A;
  logic [1:0]        forward_B;
  logic              mem_timeout;
  logic [1:0]        hz_state;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [CNT_W-1:0]  wait_cnt_tot;

  modport master (
    output rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID, rs1_EX, rs2_EX, rd_EX,
           MemRead_EX, rd_MEM, RegWrite_MEM, rd_WB, RegWrite_WB, PCSrc_EX,
           mem_access_MEM, mem_ready,
    input  EN_PC, EN_IFID, EN_IDEX, EN_EXMEM, EN_MEMWB,
           clear_IFID, clear_IDEX, clear_EXMEM, forward_A, forward_B,
           mem_timeout, hz_state, stall_cnt, flush_cnt, wait_cnt_tot
  );

  modport slave (
    input  rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID, rs1_EX, rs2_EX, rd_EX,
           MemRead_EX, rd_MEM, RegWrite_MEM, rd_WB, RegWrite_WB, PCSrc_EX,
           mem_access_MEM, mem_ready,
    output EN_PC, EN_IFID, EN_IDEX, EN_EXMEM, EN_MEMWB,
           clear_IFID, clear_IDEX, clear_EXMEM, forward_A, forward_B,
           mem_timeout, hz_state, stall_cnt, flush_cnt, wait_cnt_tot
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
// Hazard/stall/flush controller for the IF/ID/EX/MEM/WB core.
//
// Ports:
//   CLOCK - rising-edge clock.
//   RST_n - asynchronous active-low reset.
//   hz    - pipe_hazard_unit_if.slave.
//           Inputs: ID/EX/MEM/WB register indices, control bits, branch
//           resolution, and the data-memory handshake.
//           Outputs: enables, active-low clears, forwarding selects,
//           timeout flag, FSM state and perf counters.
//
// Control outputs are combinational from the inputs and the FSM state. While
// RST_n is low every enable, clear and forward select is forced to 0.
//
// Optional feature: define HAZARD_PERF_EN to build the saturating
// stall/flush/wait counters. Without it the counter ports read 0.
module pipe_hazard_unit #(
  parameter int REG_AW       = 5,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic               CLOCK,
  input  logic               RST_n,
  pipe_hazard_unit_if.slave  hz
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_WAIT  = 2'b01;
  localparam logic [1:0] ST_ERROR = 2'b10;

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(MEM_WAIT_MAX);
  localparam logic [REG_AW-1:0] REG_ZERO   = {REG_AW{1'b0}};

  // Forward select for one EX operand; the EX/MEM result is newer, so it wins
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              wr_mem,
    input logic [REG_AW-1:0] rd_mem,
    input logic              wr_wb,
    input logic [REG_AW-1:0] rd_wb
  );
    logic [1:0] sel;
    if (wr_mem && (rd_mem != REG_ZERO) && (rd_mem == rs)) begin
      sel = 2'b10;
    end else if (wr_wb && (rd_wb != REG_ZERO) && (rd_wb == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic              mem_timeout_r;
  logic              timeout_nxt_s;

  logic              freeze_s;
  logic              load_use_s;
  logic [4:0]        en_s;    // {PC, IFID, IDEX, EXMEM, MEMWB}
  logic [2:0]        clr_s;   // {IFID, IDEX, EXMEM}, active low
  logic [1:0]        fwd_a_s;
  logic [1:0]        fwd_b_s;

  // The stalled access keeps the pipe frozen until it completes.
  // Once timed out, only reset releases the freeze.
  assign freeze_s = (hz.mem_access_MEM && !hz.mem_ready) ||
                    ((state_r != ST_RUN) && !hz.mem_ready) ||
                    (state_r == ST_ERROR);

  assign load_use_s = hz.MemRead_EX && (hz.rd_EX != REG_ZERO) &&
                      ((hz.uses_rs1_ID && (hz.rs1_ID == hz.rd_EX)) ||
                       (hz.uses_rs2_ID && (hz.rs2_ID == hz.rd_EX)));

  // Memory-wait FSM next-state and timeout detection
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    timeout_nxt_s  = mem_timeout_r;
    case (state_r)
      ST_RUN: begin
        if (hz.mem_access_MEM && !hz.mem_ready) begin
          state_nxt_s    = ST_WAIT;
          wait_cnt_nxt_s = WAIT_ONE;
        end else begin
          state_nxt_s    = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (hz.mem_ready) begin
          state_nxt_s    = ST_RUN;
        end else if (wait_cnt_r < WAIT_MAX_C) begin
          wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
        end else begin
          state_nxt_s    = ST_ERROR;
          timeout_nxt_s  = 1'b1;
        end
      end
      ST_ERROR: begin
        state_nxt_s   = ST_ERROR;
        timeout_nxt_s = 1'b1;
      end
      default: begin
        // Unreachable encoding: park in ERROR so the pipe stays frozen
        state_nxt_s   = ST_ERROR;
        timeout_nxt_s = 1'b1;
      end
    endcase
  end

  // FSM, wait counter and sticky timeout registers
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      mem_timeout_r <= timeout_nxt_s;
    end
  end

  // Priority resolution: freeze > flush > load-use bubble > normal advance
  always_comb begin
    en_s    = 5'b00000;
    clr_s   = 3'b000;
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (!RST_n) begin
      en_s    = 5'b00000;
      clr_s   = 3'b000;
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end else begin
      fwd_a_s = fwd_sel(hz.rs1_EX, hz.RegWrite_MEM, hz.rd_MEM,
                        hz.RegWrite_WB, hz.rd_WB);
      fwd_b_s = fwd_sel(hz.rs2_EX, hz.RegWrite_MEM, hz.rd_MEM,
                        hz.RegWrite_WB, hz.rd_WB);
      if (freeze_s) begin
        en_s  = 5'b00000;
        clr_s = 3'b111;
      end else if (hz.PCSrc_EX) begin
        // Squash IF/ID and ID/EX. A coincident load-use is moot because
        // the dependent instruction is the one being discarded.
        en_s  = 5'b11111;
        clr_s = 3'b001;
      end else if (load_use_s) begin
        // Hold PC and IF/ID; insert one bubble into ID/EX
        en_s  = 5'b00111;
        clr_s = 3'b101;
      end else begin
        en_s  = 5'b11111;
        clr_s = 3'b111;
      end
    end
  end

  assign hz.EN_PC       = en_s[4];
  assign hz.EN_IFID     = en_s[3];
  assign hz.EN_IDEX     = en_s[2];
  assign hz.EN_EXMEM    = en_s[1];
  assign hz.EN_MEMWB    = en_s[0];
  assign hz.clear_IFID  = clr_s[2];
  assign hz.clear_IDEX  = clr_s[1];
  assign hz.clear_EXMEM = clr_s[0];
  assign hz.forward_A   = fwd_a_s;
  assign hz.forward_B   = fwd_b_s;
  assign hz.mem_timeout = mem_timeout_r;
  assign hz.hz_state    = state_r;

`ifdef HAZARD_PERF_EN
  // Saturating increment: holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             inc
  );
    logic [CNT_W-1:0] r;
    if (inc && (v != {CNT_W{1'b1}})) begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic             take_bubble_s;
  logic             take_flush_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic [CNT_W-1:0] wait_tot_r;

  // Count only the actions actually taken, after priority resolution
  assign take_flush_s  = !freeze_s && hz.PCSrc_EX;
  assign take_bubble_s = !freeze_s && !hz.PCSrc_EX && load_use_s;

  // Performance counters
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
      wait_tot_r  <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r <= sat_inc(stall_cnt_r, take_bubble_s);
      flush_cnt_r <= sat_inc(flush_cnt_r, take_flush_s);
      wait_tot_r  <= sat_inc(wait_tot_r, freeze_s);
    end
  end

  assign hz.stall_cnt    = stall_cnt_r;
  assign hz.flush_cnt    = flush_cnt_r;
  assign hz.wait_cnt_tot = wait_tot_r;
`else
  assign hz.stall_cnt    = {CNT_W{1'b0}};
  assign hz.flush_cnt    = {CNT_W{1'b0}};
  assign hz.wait_cnt_tot = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit
// Directed scoreboard bench for pipe_hazard_unit (MEM_WAIT_MAX = 4).
// The stimulus process drives one vector per cycle at posedge+1 and pushes
// the hand-computed expectation. The monitor pops entries on the following
// negedge and compares them.
module tb_pipe_hazard_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  typedef struct packed {
    logic [4:0]  en;     // {PC, IFID, IDEX, EXMEM, MEMWB}
    logic [2:0]  clr;    // {IFID, IDEX, EXMEM}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [1:0]  st;
    logic        to;
    logic        chk_perf;
    logic [31:0] s;
    logic [31:0] f;
    logic [31:0] w;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t q[$];
  int   n_chk;
  int   n_fail;
  int   vec_idx;

  pipe_hazard_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  pipe_hazard_unit #(
    .REG_AW(REG_AW), .MEM_WAIT_MAX(4), .CNT_W(CNT_W)
  ) dut (
    .CLOCK(clk),
    .RST_n(rst_n),
    .hz   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters read as zero unless the perf feature is compiled in
  function automatic logic [31:0] pv(input int v);
`ifdef HAZARD_PERF_EN
    return 32'(v);
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, vec_idx, act, exp);
    end
  endtask

  task automatic clear_in();
    bus.rs1_ID = 5'd0;  bus.rs2_ID = 5'd0;
    bus.uses_rs1_ID = 1'b0; bus.uses_rs2_ID = 1'b0;
    bus.rs1_EX = 5'd0;  bus.rs2_EX = 5'd0;  bus.rd_EX = 5'd0;
    bus.MemRead_EX = 1'b0;
    bus.rd_MEM = 5'd0;  bus.RegWrite_MEM = 1'b0;
    bus.rd_WB = 5'd0;   bus.RegWrite_WB = 1'b0;
    bus.PCSrc_EX = 1'b0;
    bus.mem_access_MEM = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic load_use_rs1();
    bus.MemRead_EX = 1'b1; bus.rd_EX = 5'd5;
    bus.rs1_ID = 5'd5; bus.uses_rs1_ID = 1'b1;
  endtask

  task automatic push(input logic [4:0] en, input logic [2:0] clr,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic [1:0] st, input logic to,
                      input logic cp, input int s, input int f, input int w);
    exp_t e;
    e.en = en; e.clr = clr; e.fa = fa; e.fb = fb; e.st = st; e.to = to;
    e.chk_perf = cp; e.s = pv(s); e.f = pv(f); e.w = pv(w);
    q.push_back(e);
  endtask

  // Monitor: pop one expectation per presented cycle and compare
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ctl", 64'({bus.EN_PC, bus.EN_IFID, bus.EN_IDEX, bus.EN_EXMEM,
                      bus.EN_MEMWB, bus.clear_IFID, bus.clear_IDEX,
                      bus.clear_EXMEM}), 64'({e.en, e.clr}));
      chk("fwd", 64'({bus.forward_A, bus.forward_B}), 64'({e.fa, e.fb}));
      chk("state", 64'(bus.hz_state), 64'(e.st));
      chk("timeout", 64'(bus.mem_timeout), 64'(e.to));
      if (e.chk_perf) begin
        chk("stall_cnt", 64'(bus.stall_cnt), 64'(e.s));
        chk("flush_cnt", 64'(bus.flush_cnt), 64'(e.f));
        chk("wait_cnt_tot", 64'(bus.wait_cnt_tot), 64'(e.w));
      end
      vec_idx++;
    end
  end

  initial begin
    n_chk = 0; n_fail = 0; vec_idx = 0;
    rst_n = 1'b0;
    clear_in();

    // v0: in reset, hazard and forward inputs active -> everything gated to 0
    next_cycle(); load_use_rs1();
    bus.RegWrite_MEM = 1'b1; bus.rd_MEM = 5'd3; bus.rs1_EX = 5'd3;
    push(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0, 0);
    // v1: release, idle
    next_cycle(); rst_n = 1'b1;
    push(5'b11111, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0, 0);
    // v2: load-use on rs1 -> one bubble
    next_cycle(); load_use_rs1();
    push(5'b00111, 3'b101, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    // v3: bubble taken once only
    next_cycle();
    push(5'b11111, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1, 0, 0);
    // v4: load writing x0 is no hazard
    next_cycle(); bus.MemRead_EX = 1'b1; bus.uses_rs1_ID = 1'b1;
    push(5'b11111, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    // v5: load-use on rs2
    next_cycle(); bus.MemRead_EX = 1'b1; bus.rd_EX = 5'd9;
    bus.rs2_ID = 5'd9; bus.uses_rs2_ID = 1'b1;
    push(5'b00111, 3'b101, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    // v6: rs2 matches but is not read
    next_cycle(); bus.MemRead_EX = 1'b1; bus.rd_EX = 5'd9; bus.rs2_ID = 5'd9;
    push(5'b11111, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    // v7: match but EX instruction is not a load
    next_cycle(); bus.rd_EX = 5'd9; bus.rs1_ID = 5'd9; bus.uses_rs1_ID = 1'b1;
    push(5'b11111, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    // v8: MEM and WB both write r7 -> EX/MEM wins
    next_cycle(); bus.RegWrite_MEM = 1'b1; bus.RegWrite_WB = 1'b1;
    bus.rd_MEM = 5'd7; bus.rd_WB = 5'd7; bus.rs1_EX = 5'd7; bus.rs2_EX = 5'd7;
    push(5'b11111, 3'b111, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    // v9: same with x0 -> never forwarded
    next_cycle(); bus.RegWrite_MEM = 1'b1; bus.RegWrite_WB = 1'b1;
    push(5'b11111, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    // v10: A from WB, B from MEM
    next_cycle(); bus.RegWrite_MEM = 1'b1; bus.RegWrite_WB = 1'b1;
    bus.rd_MEM = 5'd3; bus.rd_WB = 5'd4; bus.rs1_EX = 5'd4; bus.rs2_EX = 5'd3;
    push(5'b11111, 3'b111, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    // v11: MEM match without RegWrite_MEM falls through to WB
    next_cycle(); bus.RegWrite_WB = 1'b1;
    bus.rd_MEM = 5'd4; bus.rd_WB = 5'd4; bus.rs1_EX = 5'd4; bus.rs2_EX = 5'd4;
    push(5'b11111, 3'b111, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    // v12: WB match without RegWrite_WB -> regfile
    next_cycle(); bus.rd_WB = 5'd4; bus.rs1_EX = 5'd4;
    push(5'b11111, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    // v13: flush coincident with load-use -> flush only
    next_cycle(); load_use_rs1(); bus.PCSrc_EX = 1'b1;
    push(5'b11111, 3'b001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    // v14: stall_cnt unchanged, flush_cnt +1
    next_cycle();
    push(5'b11111, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2, 1, 0);
    // v15..v17: access not ready for 3 cycles; forwarding still live
    next_cycle(); bus.mem_access_MEM = 1'b1;
    bus.RegWrite_MEM = 1'b1; bus.rd_MEM = 5'd2; bus.rs1_EX = 5'd2;
    push(5'b00000, 3'b111, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    next_cycle(); bus.mem_access_MEM = 1'b1; bus.PCSrc_EX = 1'b1;
    push(5'b00000, 3'b111, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 0, 0, 0);
    next_cycle(); bus.mem_access_MEM = 1'b1; load_use_rs1();
    push(5'b00000, 3'b111, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 0, 0, 0);
    // v18: ready -> advance this cycle
    next_cycle(); bus.mem_access_MEM = 1'b1; bus.mem_ready = 1'b1;
    push(5'b11111, 3'b111, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 0, 0, 0);
    // v19: back in RUN; frozen flush/bubble were not counted
    next_cycle();
    push(5'b11111, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2, 1, 3);
    // v20..v24: memory never answers
    next_cycle(); bus.mem_access_MEM = 1'b1;
    push(5'b00000, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); bus.mem_access_MEM = 1'b1;
      push(5'b00000, 3'b111, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 0, 0, 0);
    end
    // v25: ERROR after 5th edge; freeze holds even with mem_ready
    next_cycle(); bus.mem_ready = 1'b1;
    push(5'b00000, 3'b111, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 2, 1, 8);
    // v26: flush request ignored in ERROR
    next_cycle(); bus.mem_ready = 1'b1; bus.PCSrc_EX = 1'b1;
    push(5'b00000, 3'b111, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 0, 0, 0);
    // v27: reset clears ERROR
    next_cycle(); rst_n = 1'b0;
    push(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0, 0);
    // v28..v29: enter MEM_WAIT again
    next_cycle(); rst_n = 1'b1; bus.mem_access_MEM = 1'b1;
    push(5'b00000, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0, 0);
    next_cycle(); bus.mem_access_MEM = 1'b1;
    push(5'b00000, 3'b111, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 0, 0, 0);
    // v30: reset mid-wait
    next_cycle(); rst_n = 1'b0;
    push(5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0, 0);
    // v31..v33: normal flow resumes
    next_cycle(); rst_n = 1'b1;
    push(5'b11111, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0, 0);
    next_cycle(); load_use_rs1();
    push(5'b00111, 3'b101, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 0);
    next_cycle();
    push(5'b11111, 3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1, 0, 0);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
